// File: rtl/nes_bus_pkg.sv
// Shared NES bus address map and the sprite-DMA state encoding.
package nes_bus_pkg;

  localparam logic [15:0] NES_PPU_REG_BASE  = 16'h2000;
  localparam logic [15:0] NES_APU_REG_BASE  = 16'h4000;
  localparam logic [15:0] NES_OAM_DATA_ADDR = NES_PPU_REG_BASE + 16'h0004;
  localparam logic [15:0] NES_DMA_REG_ADDR  = NES_APU_REG_BASE + 16'h0014;

  typedef logic [2:0] dma_state_t;

  localparam dma_state_t ST_IDLE  = 3'd0;
  localparam dma_state_t ST_HALT  = 3'd1;
  localparam dma_state_t ST_ALIGN = 3'd2;
  localparam dma_state_t ST_READ  = 3'd3;
  localparam dma_state_t ST_WRITE = 3'd4;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA engine: halts the CPU and copies one page into PPU OAM, otherwise passes the
// CPU bus straight through to memory.
module oam_dma_ctrl
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = NES_DMA_REG_ADDR,
  parameter logic [15:0] OAM_DATA_ADDR = NES_OAM_DATA_ADDR,
  parameter int unsigned XFER_LEN      = 256
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_r_nw,
  input  logic [7:0]  mem_din,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_dout,
  output logic        mem_r_nw,
  output logic        cpu_rdy,
  output logic        dma_active
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t r_state;
  dma_state_t w_state_nxt;
  logic [7:0] r_page;
  logic [7:0] r_idx;
  logic [7:0] r_data_latch;
  logic       r_parity;
  logic       w_trigger;
  logic       w_last;

  assign w_trigger = (r_state == ST_IDLE) && !cpu_r_nw && (cpu_addr == DMA_REG_ADDR);
  assign w_last    = (r_idx == LAST_IDX);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_trigger) w_state_nxt = ST_HALT;
      // An odd HALT lets READ fall straight onto the next (even) cycle.
      ST_HALT:  w_state_nxt = r_parity ? ST_READ : ST_ALIGN;
      ST_ALIGN: w_state_nxt = ST_READ;
      ST_READ:  w_state_nxt = ST_WRITE;
      ST_WRITE: w_state_nxt = w_last ? ST_IDLE : ST_READ;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_ph1 or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_page       <= 8'h00;
      r_idx        <= 8'h00;
      r_data_latch <= 8'h00;
      r_parity     <= 1'b0;
    end else begin
      r_parity <= ~r_parity;
      r_state  <= w_state_nxt;
      if (w_trigger) begin
        r_page <= cpu_dout;
        r_idx  <= 8'h00;
      end
      if (r_state == ST_READ) r_data_latch <= mem_din;
      if ((r_state == ST_WRITE) && !w_last) r_idx <= r_idx + 8'h01;
    end
  end

  always_comb begin
    mem_addr   = cpu_addr;
    mem_dout   = cpu_dout;
    mem_r_nw   = cpu_r_nw;
    cpu_rdy    = 1'b1;
    dma_active = 1'b0;
    unique case (r_state)
      ST_HALT, ST_ALIGN: begin
        mem_addr   = {r_page, 8'h00};
        mem_dout   = r_data_latch;
        mem_r_nw   = 1'b1;
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
      end
      ST_READ: begin
        mem_addr   = {r_page, r_idx};
        mem_dout   = r_data_latch;
        mem_r_nw   = 1'b1;
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
      end
      ST_WRITE: begin
        mem_addr   = OAM_DATA_ADDR;
        mem_dout   = r_data_latch;
        mem_r_nw   = 1'b0;
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: cycle-indexed transfer model checked every cycle, plus
// hand-computed expectations on transfer length, addresses and data.
module tb_oam_dma_ctrl;

  logic        clk_ph1 = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_r_nw;
  logic [7:0]  mem_din;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        mem_r_nw;
  logic        cpu_rdy;
  logic        dma_active;

  oam_dma_ctrl dut (
    .clk_ph1    (clk_ph1),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_r_nw   (cpu_r_nw),
    .mem_din    (mem_din),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .mem_r_nw   (mem_r_nw),
    .cpu_rdy    (cpu_rdy),
    .dma_active (dma_active)
  );

  always #5 clk_ph1 = ~clk_ph1;

  // Page $03 returns addr[7:0]^$5A; other pages get a different pattern.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'h03;
  endfunction

  assign mem_din = mem_byte(mem_addr);

  // Model: transfer is cycle k = 1..nhalt+512; nhalt dummy reads, then read/write pairs.
  logic       m_busy;
  logic       m_par;
  int         m_k;
  int         m_nhalt;
  logic [7:0] m_page;

  always @(posedge clk_ph1 or negedge rst) begin
    if (!rst) begin
      m_busy  <= 1'b0;
      m_par   <= 1'b0;
      m_k     <= 0;
      m_nhalt <= 1;
      m_page  <= 8'h00;
    end else begin
      m_par <= ~m_par;
      if (m_busy) begin
        if (m_k == m_nhalt + 512) m_busy <= 1'b0;
        else m_k <= m_k + 1;
      end else if (!cpu_r_nw && cpu_addr == 16'h4014) begin
        m_busy  <= 1'b1;
        m_k     <= 1;
        m_page  <= cpu_dout;
        m_nhalt <= m_par ? 2 : 1;
      end
    end
  end

  int          n_checks = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;
  int          rdy_low_cnt = 0;
  logic [15:0] last_rd = 16'h0000;
  logic [7:0]  wr_data   [2048];
  logic [15:0] rd_before [2048];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_monitor();
    logic [15:0] e_addr;
    logic        e_rnw;
    logic [7:0]  e_dout;
    int          j;
    logic [7:0]  b;
    forever begin
      @(negedge clk_ph1);
      if (rst) begin
        if (!m_busy) begin
          check("idle_rdy", 32'(cpu_rdy), 32'd1);
          check("idle_act", 32'(dma_active), 32'd0);
          check("idle_addr", 32'(mem_addr), 32'(cpu_addr));
          check("idle_dout", 32'(mem_dout), 32'(cpu_dout));
          check("idle_rnw", 32'(mem_r_nw), 32'(cpu_r_nw));
        end else begin
          e_dout = 8'h00;
          if (m_k <= m_nhalt) begin
            e_addr = {m_page, 8'h00};
            e_rnw  = 1'b1;
          end else begin
            j = m_k - m_nhalt - 1;
            b = 8'(j / 2);
            if (j % 2 == 0) begin
              e_addr = {m_page, b};
              e_rnw  = 1'b1;
            end else begin
              e_addr = 16'h2004;
              e_rnw  = 1'b0;
              e_dout = mem_byte({m_page, b});
            end
          end
          check("busy_rdy", 32'(cpu_rdy), 32'd0);
          check("busy_act", 32'(dma_active), 32'd1);
          check("busy_addr", 32'(mem_addr), 32'(e_addr));
          check("busy_rnw", 32'(mem_r_nw), 32'(e_rnw));
          if (!e_rnw) check("busy_dout", 32'(mem_dout), 32'(e_dout));
        end
        if (!cpu_rdy) rdy_low_cnt++;
        if (dma_active && mem_r_nw) last_rd = mem_addr;
        if (dma_active && !mem_r_nw && mem_addr == 16'h2004) begin
          wr_data[wr_cnt % 2048]   = mem_dout;
          rd_before[wr_cnt % 2048] = last_rd;
          wr_cnt++;
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_ph1);
    #1;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a;
    cpu_dout = d;
    cpu_r_nw = 1'b0;
    tick(1);
    cpu_addr = 16'h1234;
    cpu_dout = 8'h00;
    cpu_r_nw = 1'b1;
  endtask

  // An odd HALT follows a trigger issued on an even cycle.
  task automatic trigger(input logic [7:0] pg, input bit halt_odd);
    if (m_par != (halt_odd ? 1'b0 : 1'b1)) tick(1);
    cpu_wr(16'h4014, pg);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (dma_active && n < 1000) begin
      tick(1);
      n++;
    end
    check({name, "_done"}, 32'(dma_active), 32'd0);
  endtask

  int base_w;
  int base_r;
  int n;

  initial begin
    cpu_addr = 16'h1234;
    cpu_dout = 8'h00;
    cpu_r_nw = 1'b1;
    rst      = 1'b0;
    fork
      run_monitor();
    join_none

    // Reset and pass-through
    tick(3);
    check("rst_rdy", 32'(cpu_rdy), 32'd1);
    check("rst_act", 32'(dma_active), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'h1234);
    @(negedge clk_ph1);
    rst = 1'b1;
    tick(1);
    cpu_addr = 16'hABCD;
    #1;
    check("pass_addr", 32'(mem_addr), 32'hABCD);
    cpu_addr = 16'h1234;
    tick(1);

    // Odd HALT, page $02
    base_w = wr_cnt;
    base_r = rdy_low_cnt;
    trigger(8'h02, 1'b1);
    wait_done("odd");
    check("odd_rdy_low", 32'(rdy_low_cnt - base_r), 32'd513);
    check("odd_writes", 32'(wr_cnt - base_w), 32'd256);
    check("odd_first_rd", 32'(rd_before[base_w % 2048]), 32'h0200);
    check("odd_last_rd", 32'(rd_before[(base_w + 255) % 2048]), 32'h02FF);

    // Even HALT, page $02: one ALIGN cycle
    tick(2);
    base_w = wr_cnt;
    base_r = rdy_low_cnt;
    trigger(8'h02, 1'b0);
    wait_done("even");
    check("even_rdy_low", 32'(rdy_low_cnt - base_r), 32'd514);
    check("even_writes", 32'(wr_cnt - base_w), 32'd256);
    check("even_last_rd", 32'(rd_before[(base_w + 255) % 2048]), 32'h02FF);

    // Data integrity, page $03
    tick(3);
    base_w = wr_cnt;
    trigger(8'h03, 1'b1);
    wait_done("data");
    check("data_writes", 32'(wr_cnt - base_w), 32'd256);
    check("data_first", 32'(wr_data[base_w % 2048]), 32'h5A);
    check("data_second", 32'(wr_data[(base_w + 1) % 2048]), 32'h5B);
    check("data_last", 32'(wr_data[(base_w + 255) % 2048]), 32'hA5);
    for (int i = 0; i < 256; i++) begin
      check("data_seq", 32'(wr_data[(base_w + i) % 2048]), 32'(8'(i) ^ 8'h5A));
    end

    // Non-triggers
    tick(2);
    cpu_wr(16'h4015, 8'h01);
    check("ntrig_4015", 32'(dma_active), 32'd0);
    cpu_wr(16'h4013, 8'h01);
    check("ntrig_4013", 32'(dma_active), 32'd0);
    cpu_addr = 16'h4014;
    cpu_r_nw = 1'b1;
    tick(1);
    cpu_addr = 16'h1234;
    check("ntrig_rd4014", 32'(dma_active), 32'd0);
    tick(1);

    // Second $4014 write while busy is ignored
    base_w = wr_cnt;
    base_r = rdy_low_cnt;
    trigger(8'h04, 1'b1);
    tick(20);
    cpu_wr(16'h4014, 8'h07);
    wait_done("busy_wr");
    check("busy_wr_writes", 32'(wr_cnt - base_w), 32'd256);
    check("busy_wr_rdy_low", 32'(rdy_low_cnt - base_r), 32'd513);
    check("busy_wr_first_rd", 32'(rd_before[base_w % 2048]), 32'h0400);
    check("busy_wr_last_rd", 32'(rd_before[(base_w + 255) % 2048]), 32'h04FF);

    // Reset after the 100th OAM write
    tick(2);
    base_w = wr_cnt;
    trigger(8'h05, 1'b0);
    n = 0;
    while ((wr_cnt - base_w) < 100 && n < 1000) begin
      tick(1);
      n++;
    end
    check("mid_reached", 32'(wr_cnt - base_w), 32'd100);
    rst = 1'b0;
    #1;
    check("mid_rst_rdy", 32'(cpu_rdy), 32'd1);
    check("mid_rst_act", 32'(dma_active), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'h1234);
    check("mid_rst_rnw", 32'(mem_r_nw), 32'd1);
    tick(2);
    @(negedge clk_ph1);
    rst = 1'b1;
    tick(3);
    check("mid_total", 32'(wr_cnt - base_w), 32'd100);
    base_w = wr_cnt;
    trigger(8'h06, 1'b1);
    wait_done("fresh");
    check("fresh_writes", 32'(wr_cnt - base_w), 32'd256);
    check("fresh_last_rd", 32'(rd_before[(base_w + 255) % 2048]), 32'h06FF);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sprite-DMA engine that sits directly downstream of the 6502 CPU core, between the CPU bus (Addr_bus, Data_bus_out, R_nW) and the system memory/PPU bus.
- A CPU write to $4014 starts a transfer: the engine halts the CPU via RDY and copies 256 bytes from page {value,$00..$FF} into the PPU OAM data port at $2004.
- When idle, it passes the CPU bus straight through to memory.

Parameters:
- DMA_REG_ADDR, 16'h4014, trigger register address.
- OAM_DATA_ADDR, 16'h2004, PPU OAM data port written for each byte.
- XFER_LEN, 256, bytes per transfer; must be a power of two, at most 256.

Ports:
- clk_ph1  in  1  single system clock; all flops on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_addr  in  16  CPU Addr_bus.
- cpu_dout  in  8  CPU Data_bus_out.
- cpu_r_nw  in  1  CPU R_nW; 1 means read.
- mem_din  in  8  read data returned from the memory bus; also fed to the CPU Data_bus_in externally.
- mem_addr  out  16  address to the memory bus.
- mem_dout  out  8  write data to the memory bus.
- mem_r_nw  out  1  read/write strobe to the memory bus.
- cpu_rdy  out  1  0 halts the CPU.
- dma_active  out  1  1 while the engine owns the bus.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, page=0, idx=0, data_latch=0, parity=0.
  - cpu_rdy=1, dma_active=0; outputs in pass-through.
- parity flop: toggles every clk_ph1 edge from reset. Even cycle means parity=0.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - mem_addr=cpu_addr, mem_dout=cpu_dout, mem_r_nw=cpu_r_nw (combinational).
  - The trigger write itself passes through to memory.
  - If cpu_r_nw=0 and cpu_addr==DMA_REG_ADDR at a clock edge: page<=cpu_dout, idx<=0, go to HALT.
- HALT:
  - cpu_rdy=0, dma_active=1; dummy read with mem_addr={page,8'h00}, mem_r_nw=1.
  - If parity=1 in this cycle, go to READ; else go to ALIGN.
- ALIGN: same dummy read as HALT; go to READ. Result: every READ lands on an even cycle.
- READ:
  - mem_addr={page,idx}, mem_r_nw=1.
  - data_latch<=mem_din at the end of the cycle; go to WRITE.
- WRITE:
  - mem_addr=OAM_DATA_ADDR, mem_dout=data_latch, mem_r_nw=0.
  - If idx==XFER_LEN-1, go to IDLE; else idx<=idx+1 (8-bit, no wrap beyond XFER_LEN) and go to READ.
- In every state except IDLE: cpu_rdy=0, dma_active=1, and CPU bus inputs are ignored.
- Latency: cpu_rdy is low for exactly 513 cycles (HALT odd) or 514 cycles (HALT even), starting the cycle after the trigger edge.
- cpu_rdy returns to 1 and pass-through resumes in the cycle after the final WRITE.
- Boundaries:
  - A write to $4014 while busy is ignored.
  - A trigger in the same cycle the engine returns to IDLE cannot occur, because the CPU is halted during that cycle.
  - Page $FF reads $FF00-$FFFF; idx never carries into page.
  - Reset mid-transfer aborts immediately: outputs return to pass-through and cpu_rdy=1 asynchronously; no further $2004 writes.
  - Writes to $4013 or $4015, and reads of $4014, never trigger.

Decomposition:
- Shared package nes_bus_pkg holds:
  - address constants: DMA_REG_ADDR, OAM_DATA_ADDR, PPU/APU register bases;
  - the dma_state_t encoding (IDLE, HALT, ALIGN, READ, WRITE).
- No sub-module; the parity flop, index counter and bus mux stay inline.
- Target size: about 150 lines of RTL.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release → cpu_rdy=1, dma_active=0, mem_addr tracks cpu_addr=16'h1234 combinationally.
- Trigger on a cycle that makes HALT odd: write 8'h02 to $4014 → cpu_rdy low for exactly 513 cycles; first READ addr $0200, first WRITE addr $2004, last READ $02FF.
- Same trigger shifted one cycle so HALT is even → exactly one ALIGN cycle, cpu_rdy low for 514 cycles; all READs on parity=0.
- Data integrity: memory model returns (addr[7:0]^8'h5A) for page $03 → the 256 writes to $2004 carry $5A,$5B,…,$A5 in order, with no extra or missing writes.
- Reset mid-transfer: assert rst=0 after the 100th $2004 write → same-cycle cpu_rdy=1 and pass-through; 100 writes total. A fresh trigger afterwards completes all 256 writes.
- Non-triggers: write $4015, write $4013, read $4014 → dma_active stays 0. A second $4014 write during an active transfer → transfer length unchanged, page unchanged.
